dmem_lsu: RTL and testbench

//  Byte-addressed RV32 data memory with integrated load/store unit: owns the

---
 rtl/dmem_lsu.sv | 142 ++++++++++++++
 tb/tb_dmem_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Byte-addressed RV32 data memory with built-in load/store alignment and extension.
// One outstanding request; load data and error status are registered into the response.
//
// state  | meaning
// S_IDLE | ready for a request, no response pending
// S_RESP | response (rdata/rsp_err) presented, waiting for rsp_ready
module dmem_lsu #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2**(DM_ADDRESS-2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [2:0]            funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DM_ADDRESS-3:0] word;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            off;
  logic                  accept;
  logic                  req_err;
  logic [3:0]            be;
  logic [DATA_W-1:0]     wlane;
  logic [DATA_W-1:0]     rd_word;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_W-1:0]     load_v;

  assign word    = addr[DM_ADDRESS-1:2];
  assign idx     = word[IDX_W-1:0];
  assign off     = addr[1:0];
  assign accept  = req_valid && (state_q == S_IDLE);
  assign rd_word = mem_q[idx];
  assign byte_v  = rd_word[8*off +: 8];
  assign half_v  = rd_word[16*off[1] +: 16];

  always_comb begin
    req_err = 1'b0;
    case (funct3)
      3'b000:         req_err = 1'b0;
      3'b001:         req_err = off[0];
      3'b010:         req_err = (off != 2'b00);
      3'b100, 3'b101: req_err = req_we;
      default:        req_err = 1'b1;
    endcase
    if (funct3 == 3'b101 && off[0]) req_err = 1'b1;
    if (int'(word) >= DEPTH) req_err = 1'b1;
  end

  // Stores replicate the source onto every lane; byte enables pick the live ones.
  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    load_v = rd_word;
    case (funct3)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_v = {24'h0, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b101:  load_v = {16'h0, half_v};
      default: load_v = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RESP;
          err_d   = req_err;
          rdata_d = (req_err || req_we) ? '0 : load_v;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rdata     = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vectors plus random traffic
// against a byte-array reference model.
module tb_dmem_lsu;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mem_m [512];

  dmem_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rdata(rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: little-endian byte array, natural alignment, RV32 extension rules.
  function automatic void ref_op(input logic we, input logic [8:0] a, input logic [31:0] wd,
                                 input logic [2:0] f3, output logic [31:0] r, output logic e);
    int size;
    logic [31:0] val;
    size = 1 << f3[1:0];
    e = 1'b0;
    r = '0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
    else if (we && f3[2]) e = 1'b1;
    else if ((int'(a) % size) != 0) e = 1'b1;
    else if ((int'(a) / 4) >= DEPTH) e = 1'b1;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < size; i++) val = val | (32'(mem_m[int'(a) + i]) << (8*i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        r = val;
      end
    end
  endfunction

  task automatic xact(input logic we, input logic [8:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] r, output logic e);
    logic [31:0] er;
    logic        ee;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; addr = a; wdata = wd; funct3 = f3;
    ref_op(we, a, wd, f3, er, ee);
    @(posedge clk); #1;
    req_valid = 1'b0;
    r = rdata;
    e = rsp_err;
    check("rsp_valid_lat1", 32'(rsp_valid), 32'd1);
    check("rdata", rdata, er);
    check("rsp_err", 32'(rsp_err), 32'(ee));
    @(posedge clk); #1;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] held;
    logic [2:0]  f3;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; addr = '0;
    wdata = '0; funct3 = 3'b010; rsp_ready = 1'b1;
    #23;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) xact(1'b1, 9'(w*4), $urandom, 3'b010, r, e);

    xact(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, r, e);
    xact(1'b0, 9'h010, 32'h0, 3'b010, r, e);
    check("lw_deadbeef", r, 32'hDEADBEEF);

    xact(1'b1, 9'h010, 32'h11223344, 3'b010, r, e);
    xact(1'b1, 9'h013, 32'h000000A5, 3'b000, r, e);
    check("sb_rdata0", r, 32'h0);
    xact(1'b0, 9'h010, 32'h0, 3'b010, r, e);
    check("lw_after_sb", r, 32'hA5223344);
    xact(1'b0, 9'h013, 32'h0, 3'b000, r, e);
    check("lb_sext", r, 32'hFFFFFFA5);
    xact(1'b0, 9'h013, 32'h0, 3'b100, r, e);
    check("lbu_zext", r, 32'h000000A5);

    xact(1'b1, 9'h020, 32'h0, 3'b010, r, e);
    xact(1'b1, 9'h022, 32'h00008001, 3'b001, r, e);
    xact(1'b0, 9'h022, 32'h0, 3'b001, r, e);
    check("lh_sext", r, 32'hFFFF8001);
    xact(1'b0, 9'h022, 32'h0, 3'b101, r, e);
    check("lhu_zext", r, 32'h00008001);
    xact(1'b0, 9'h020, 32'h0, 3'b010, r, e);
    check("lw_after_sh", r, 32'h80010000);

    xact(1'b0, 9'h011, 32'h0, 3'b010, r, e);
    check("err_lw_mis", 32'(e), 32'd1);
    xact(1'b0, 9'h021, 32'h0, 3'b001, r, e);
    check("err_lh_mis", 32'(e), 32'd1);
    xact(1'b1, 9'h012, 32'hFFFFFFFF, 3'b010, r, e);
    check("err_sw_mis", 32'(e), 32'd1);
    xact(1'b0, 9'h010, 32'h0, 3'b011, r, e);
    check("err_f3_011", 32'(e), 32'd1);
    check("err_rdata0", r, 32'h0);
    xact(1'b1, 9'h010, 32'hFFFFFFFF, 3'b100, r, e);
    check("err_sbu", 32'(e), 32'd1);
    xact(1'b0, 9'h010, 32'h0, 3'b010, r, e);
    check("mem_unchanged_10", r, 32'hA5223344);
    xact(1'b0, 9'h020, 32'h0, 3'b010, r, e);
    check("mem_unchanged_20", r, 32'h80010000);

    // Backpressure: response held, intruding store ignored.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; addr = 9'h010; funct3 = 3'b010;
    @(posedge clk); #1;
    held = rdata;
    check("bp_first", held, 32'hA5223344);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; addr = 9'h010; wdata = 32'h0; funct3 = 3'b010;
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata_held", rdata, 32'hA5223344);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'(rsp_valid), 32'd0);
    xact(1'b0, 9'h010, 32'h0, 3'b010, r, e);
    check("bp_ignored", r, 32'hA5223344);

    repeat (600) begin
      case ($urandom_range(0, 9))
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6:       f3 = 3'b100;
        7:       f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      xact(1'($urandom), 9'($urandom), $urandom, f3, r, e);
    end

    // Reset in the middle of a pending response.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; addr = 9'h020; funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("prerst_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    check("postrst_ready", 32'(req_ready), 32'd1);
    for (int w = 0; w < 8; w++) xact(1'b0, 9'(w*4 + 64), 32'h0, 3'b010, r, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
